// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-4 demux router.
// Channel count, select width, per-channel slot state and the select decoder.
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // One-hot decode of the destination channel.
  function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] s);
    logic [NUM_CH-1:0] oh;
    case (s)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      2'd3:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/demux_chan_slot.sv
// One output channel: a single-entry registered slot with valid/ready
// handshake and a saturating count of delivered beats.
module demux_chan_slot
  import demux_pkg::*;
#(
  parameter int DW    = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DW-1:0]    din,
  input  logic             out_ready,
  input  logic             cnt_clr,
  output logic             out_valid,
  output logic [DW-1:0]    dout,
  output logic [CNT_W-1:0] cnt,
  output logic             can_accept
);

  slot_state_e      state_r;
  logic [DW-1:0]    data_r;
  logic [CNT_W-1:0] cnt_r;
  logic             drain_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    else    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Handshake decode: a full slot that is being drained frees itself this edge.
  always_comb begin
    drain_s    = 1'b0;
    can_accept = 1'b0;
    if (state_r == SLOT_FULL) begin
      drain_s    = out_ready;
      can_accept = out_ready;
    end else begin
      drain_s    = 1'b0;
      can_accept = 1'b1;
    end
  end

  // Slot state and data; data only changes on a load, so it is stable while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= SLOT_EMPTY;
      data_r  <= {DW{1'b0}};
    end else begin
      case (state_r)
        SLOT_EMPTY: begin
          if (load) begin
            state_r <= SLOT_FULL;
            data_r  <= din;
          end
        end
        SLOT_FULL: begin
          if (load) begin
            data_r <= din;
          end else if (out_ready) begin
            state_r <= SLOT_EMPTY;
          end
        end
        default: begin
          state_r <= SLOT_EMPTY;
          data_r  <= {DW{1'b0}};
        end
      endcase
    end
  end

  // Delivered-beat counter; clear has priority over a same-cycle drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (drain_s) begin
      cnt_r <= sat_inc(cnt_r);
    end
  end

  assign out_valid = (state_r == SLOT_FULL);
  assign dout      = data_r;
  assign cnt       = cnt_r;

endmodule

// File: rtl/demux1to4_router.sv
// Routes one valid/ready input stream to one of four registered output
// channels chosen per beat by sel; in_ready is the only combinational output.
module demux1to4_router
  import demux_pkg::*;
#(
  parameter int DW    = 2,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [DW-1:0]           din,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*DW-1:0]    dout,
  input  logic                    cnt_clr,
  output logic [NUM_CH*CNT_W-1:0] cnt
);

  logic [NUM_CH-1:0] can_accept_s;
  logic [NUM_CH-1:0] load_s;

  assign in_ready = can_accept_s[sel];

  // Only the addressed channel sees a load, and only on an accepted beat.
  always_comb begin
    load_s = 4'b0000;
    if (in_valid && in_ready) begin
      load_s = sel_onehot(sel);
    end else begin
      load_s = 4'b0000;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    demux_chan_slot #(
      .DW    (DW),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .load       (load_s[k]),
      .din        (din),
      .out_ready  (out_ready[k]),
      .cnt_clr    (cnt_clr),
      .out_valid  (out_valid[k]),
      .dout       (dout[k*DW +: DW]),
      .cnt        (cnt[k*CNT_W +: CNT_W]),
      .can_accept (can_accept_s[k])
    );
  end

endmodule

// File: tb/tb_demux1to4_router.sv
// Directed self-checking bench for demux1to4_router; a second instance with
// CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_demux1to4_router;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  sel;
  logic [1:0]  din;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [7:0]  dout;
  logic        cnt_clr;
  logic [31:0] cnt;

  logic        in_ready_b;
  logic [3:0]  out_valid_b;
  logic [7:0]  dout_b;
  logic [7:0]  cnt_b;

  int errors = 0;
  int checks = 0;

  demux1to4_router #(.DW(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .din(din), .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .cnt_clr(cnt_clr), .cnt(cnt)
  );

  demux1to4_router #(.DW(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .sel(sel), .din(din), .out_valid(out_valid_b), .out_ready(out_ready),
    .dout(dout_b), .cnt_clr(cnt_clr), .cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] rt_sel [4];
    logic [3:0] exp_v;
    rt_sel = '{2'd0, 2'd3, 2'd1, 2'd2};

    rst = 1'b1; in_valid = 1'b0; sel = 2'd0; din = 2'd0;
    out_ready = 4'h0; cnt_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", {28'd0, out_valid}, 32'd0);
    chk("rst_dout", {24'd0, dout}, 32'd0);
    chk("rst_cnt", cnt, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // routing: each beat shows up only on its channel one cycle later
    out_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; sel = rt_sel[i]; din = rt_sel[i];
      tick();
      exp_v = 4'b0001 << rt_sel[i];
      chk("route_valid", {28'd0, out_valid}, {28'd0, exp_v});
      chk("route_dout", {30'd0, dout[rt_sel[i]*2 +: 2]}, {30'd0, rt_sel[i]});
    end
    in_valid = 1'b0;
    tick();
    chk("route_idle", {28'd0, out_valid}, 32'd0);
    chk("route_cnt", cnt, 32'h01010101);

    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_cnt", cnt, 32'd0);

    // throughput: 16 back-to-back beats to ch0
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; sel = 2'd0; din = i[1:0];
      #1;
      chk("tp_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("tp_valid", {31'd0, out_valid[0]}, 32'd1);
      chk("tp_dout", {30'd0, dout[1:0]}, {30'd0, i[1:0]});
    end
    in_valid = 1'b0;
    tick();
    chk("tp_cnt", cnt, 32'h00000010);
    chk("tp_cnt_sat", {24'd0, cnt_b}, 32'h03);

    // backpressure on ch1
    out_ready = 4'b1101;
    in_valid = 1'b1; sel = 2'd1; din = 2'b01;
    tick();
    chk("bp_first_valid", {28'd0, out_valid}, 32'b0010);
    chk("bp_first_dout", {30'd0, dout[3:2]}, 32'b01);
    din = 2'b10;
    #1;
    chk("bp_stall_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("bp_hold_dout", {30'd0, dout[3:2]}, 32'b01);
    chk("bp_hold_valid", {31'd0, out_valid[1]}, 32'd1);

    // ch1 stalled must not block ch3
    sel = 2'd3; din = 2'b11;
    #1;
    chk("nb_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("nb_valid", {28'd0, out_valid}, 32'b1010);
    chk("nb_dout", {30'd0, dout[7:6]}, 32'b11);

    // release ch1: old beat drains while the new one loads on the same edge
    sel = 2'd1; din = 2'b10; out_ready = 4'hF;
    #1;
    chk("bp_rel_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_rel_valid", {28'd0, out_valid}, 32'b0010);
    chk("bp_rel_dout", {30'd0, dout[3:2]}, 32'b10);
    in_valid = 1'b0;
    tick();
    chk("bp_idle", {28'd0, out_valid}, 32'd0);
    chk("bp_cnt", cnt, 32'h01000210);

    // saturation: five drains on ch2
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; sel = 2'd2; din = 2'd2;
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("sat_cnt_w2", {24'd0, cnt_b}, 32'h30);
    chk("sat_cnt_w8", cnt, 32'h00050000);

    // reset mid-run with ch2 full
    out_ready = 4'h0;
    in_valid = 1'b1; sel = 2'd2; din = 2'd1;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", {28'd0, out_valid}, 32'b0100);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {28'd0, out_valid}, 32'd0);
    chk("mid_rst_cnt", cnt, 32'd0);
    chk("mid_rst_dout", {24'd0, dout}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("post_rst_valid", {28'd0, out_valid}, 32'd0);

    // clear wins over a same-cycle drain
    out_ready = 4'hF;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; sel = 2'd2; din = 2'd3;
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("pre_clr_cnt", cnt, 32'h00020000);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_drain_cnt", cnt, 32'd0);
    chk("clr_drain_cnt_w2", {24'd0, cnt_b}, 32'd0);
    chk("clr_drain_valid", {28'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
